// File: rtl/id_fwd_stage.sv
// MIPS decode stage: decode, multi-source operand forwarding, ID-stage branch
// resolution, load-use bubble insertion and the ID/EX pipeline register.
module id_fwd_stage #(
   parameter int NUM_FWD        = 2,
   parameter int LOAD_USE_CHECK = 1,
   parameter int DELAY_SLOT     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           pc_i,
   input  logic [31:0]           inst_i,
   input  logic [31:0]           reg1_data_i,
   input  logic [31:0]           reg2_data_i,
   input  logic [NUM_FWD-1:0]    fwd_we_i,
   input  logic [5*NUM_FWD-1:0]  fwd_wd_i,
   input  logic [32*NUM_FWD-1:0] fwd_wdata_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   output logic [4:0]            reg1_addr_o,
   output logic [4:0]            reg2_addr_o,
   output logic                  reg1_read_o,
   output logic                  reg2_read_o,
   output logic                  stallreq_o,
   output logic                  branch_flag_o,
   output logic [31:0]           branch_addr_o,
   output logic                  squash_next_o,
   output logic [7:0]            ex_aluop_o,
   output logic [2:0]            ex_alusel_o,
   output logic [31:0]           ex_reg1_o,
   output logic [31:0]           ex_reg2_o,
   output logic [4:0]            ex_wd_o,
   output logic                  ex_wreg_o,
   output logic                  ex_in_delay_slot_o
);

   localparam logic [7:0] ALU_NOP = 8'h00;
   localparam logic [7:0] ALU_AND = 8'h24;
   localparam logic [7:0] ALU_OR  = 8'h25;
   localparam logic [7:0] ALU_XOR = 8'h26;
   localparam logic [7:0] ALU_NOR = 8'h27;
   localparam logic [7:0] ALU_LW  = 8'hE3;
   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_LS    = 3'b111;
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic        in_ds;
   } ex_t;

   ex_t         ex_d, ex_q;
   logic        ds_d, ds_q;
   logic [7:0]  dec_aluop;
   logic [2:0]  dec_alusel;
   logic [4:0]  dec_wd;
   logic        dec_wreg;
   logic [31:0] imm;
   logic        is_beq, is_bne, is_j;
   logic [31:0] op1, op2, pc_plus4, br_target;
   logic        taken, load_use;

   // Lowest-index matching source wins; r0 always reads as zero.
   function automatic logic [31:0] fwd_pick(input logic [4:0] addr, input logic [31:0] rf_data,
                                            input logic [NUM_FWD-1:0] we,
                                            input logic [5*NUM_FWD-1:0] wd,
                                            input logic [32*NUM_FWD-1:0] wdata);
      logic [31:0] val;
      logic        hit;
      val = rf_data;
      hit = 1'b0;
      for (int k = 0; k < NUM_FWD; k++) begin
         if (!hit && we[k] && wd[5*k +: 5] == addr) begin
            val = wdata[32*k +: 32];
            hit = 1'b1;
         end
      end
      if (addr == 5'd0) val = '0;
      return val;
   endfunction

   always_comb begin
      dec_aluop   = ALU_NOP;
      dec_alusel  = SEL_NOP;
      dec_wd      = inst_i[15:11];
      dec_wreg    = 1'b0;
      imm         = '0;
      reg1_addr_o = inst_i[25:21];
      reg2_addr_o = inst_i[20:16];
      reg1_read_o = 1'b0;
      reg2_read_o = 1'b0;
      is_beq      = 1'b0;
      is_bne      = 1'b0;
      is_j        = 1'b0;
      case (inst_i[31:26])
         OP_ORI, OP_ANDI, OP_XORI: begin
            case (inst_i[31:26])
               OP_ANDI: dec_aluop = ALU_AND;
               OP_XORI: dec_aluop = ALU_XOR;
               default: dec_aluop = ALU_OR;
            endcase
            dec_alusel  = SEL_LOGIC;
            reg1_read_o = 1'b1;
            dec_wd      = inst_i[20:16];
            dec_wreg    = 1'b1;
            imm         = {16'h0, inst_i[15:0]};
         end
         OP_LUI: begin
            dec_aluop   = ALU_OR;
            dec_alusel  = SEL_LOGIC;
            reg1_read_o = 1'b1;
            reg1_addr_o = 5'd0;
            imm         = {inst_i[15:0], 16'h0};
            dec_wd      = inst_i[20:16];
            dec_wreg    = 1'b1;
         end
         OP_SPECIAL: begin
            if (inst_i[10:6] == 5'd0 && inst_i[5:2] == 4'b1001) begin
               case (inst_i[1:0])
                  2'b00:   dec_aluop = ALU_AND;
                  2'b01:   dec_aluop = ALU_OR;
                  2'b10:   dec_aluop = ALU_XOR;
                  default: dec_aluop = ALU_NOR;
               endcase
               dec_alusel  = SEL_LOGIC;
               reg1_read_o = 1'b1;
               reg2_read_o = 1'b1;
               dec_wreg    = 1'b1;
            end
         end
         OP_LW: begin
            dec_aluop   = ALU_LW;
            dec_alusel  = SEL_LS;
            reg1_read_o = 1'b1;
            imm         = {{16{inst_i[15]}}, inst_i[15:0]};
            dec_wd      = inst_i[20:16];
            dec_wreg    = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            reg1_read_o = 1'b1;
            reg2_read_o = 1'b1;
            is_beq      = (inst_i[31:26] == OP_BEQ);
            is_bne      = (inst_i[31:26] == OP_BNE);
         end
         OP_J:    is_j = 1'b1;
         default: ;
      endcase
   end

   assign op1 = reg1_read_o ? fwd_pick(reg1_addr_o, reg1_data_i, fwd_we_i, fwd_wd_i, fwd_wdata_i) : imm;
   assign op2 = reg2_read_o ? fwd_pick(reg2_addr_o, reg2_data_i, fwd_we_i, fwd_wd_i, fwd_wdata_i) : imm;

   assign pc_plus4  = pc_i + 32'd4;
   assign br_target = is_j ? {pc_plus4[31:28], inst_i[25:0], 2'b00}
                           : pc_plus4 + {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
   assign taken     = is_j || (is_beq && op1 == op2) || (is_bne && op1 != op2);

   // Control contract: stall_i holds the ID/EX register and flush_i loads a NOP
   // (flush wins). stallreq_o asks ctrl to hold IF/ID for one cycle while this
   // stage itself drops a bubble into EX; no branch is reported meanwhile.
   assign load_use = (LOAD_USE_CHECK != 0) && ex_q.aluop == ALU_LW && ex_q.wreg && ex_q.wd != 5'd0 &&
                     ((reg1_read_o && reg1_addr_o == ex_q.wd) || (reg2_read_o && reg2_addr_o == ex_q.wd));

   assign stallreq_o    = load_use;
   assign branch_flag_o = taken && !load_use;
   assign branch_addr_o = branch_flag_o ? br_target : 32'h0;
   assign squash_next_o = (DELAY_SLOT == 0) && branch_flag_o;

   always_comb begin
      ex_d = ex_q;
      ds_d = ds_q;
      if (flush_i) begin
         ex_d = '0;
         ds_d = 1'b0;
      end else if (!stall_i) begin
         if (load_use) begin
            ex_d = '0;
         end else begin
            ex_d.aluop  = dec_aluop;
            ex_d.alusel = dec_alusel;
            ex_d.reg1   = op1;
            ex_d.reg2   = op2;
            ex_d.wd     = dec_wd;
            ex_d.wreg   = dec_wreg;
            ex_d.in_ds  = ds_q;
            ds_d        = (DELAY_SLOT != 0) && branch_flag_o;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
         ds_q <= 1'b0;
      end else begin
         ex_q <= ex_d;
         ds_q <= ds_d;
      end
   end

   assign ex_aluop_o         = ex_q.aluop;
   assign ex_alusel_o        = ex_q.alusel;
   assign ex_reg1_o          = ex_q.reg1;
   assign ex_reg2_o          = ex_q.reg2;
   assign ex_wd_o            = ex_q.wd;
   assign ex_wreg_o          = ex_q.wreg;
   assign ex_in_delay_slot_o = ex_q.in_ds;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: two instances (default params, and no load-use check
// with squash-style branches) share stimulus and are scored against a model.
module tb_id_fwd_stage;

   localparam int NF = 2;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic        ids;
   } ex_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      pc_i, inst_i, reg1_data_i, reg2_data_i;
   logic [NF-1:0]    fwd_we_i;
   logic [5*NF-1:0]  fwd_wd_i;
   logic [32*NF-1:0] fwd_wdata_i;
   logic             stall_i, flush_i;

   logic [31:0]      nx_r1, nx_r2;
   logic [NF-1:0]    nx_we;
   logic [5*NF-1:0]  nx_wd;
   logic [32*NF-1:0] nx_wdata;

   logic [4:0]  a_r1a, a_r2a, b_r1a, b_r2a, a_ex_wd, b_ex_wd;
   logic        a_r1r, a_r2r, a_stl, a_bf, a_sq, b_r1r, b_r2r, b_stl, b_bf, b_sq;
   logic [31:0] a_ba, b_ba, a_ex_reg1, a_ex_reg2, b_ex_reg1, b_ex_reg2;
   logic [7:0]  a_ex_aluop, b_ex_aluop;
   logic [2:0]  a_ex_alusel, b_ex_alusel;
   logic        a_ex_wreg, b_ex_wreg, a_ex_ids, b_ex_ids;

   logic [46:0] a_comb, b_comb;
   logic [81:0] a_ex, b_ex;
   logic [46:0] comb_a_q[$], comb_b_q[$];
   logic [81:0] exp_a_q[$], exp_b_q[$];
   ex_t         st_a, st_b;
   logic        ds_a, ds_b;
   logic        mon_en = 1'b0;
   int          total = 0;
   int          bad = 0;

   id_fwd_stage #(.NUM_FWD(NF), .LOAD_USE_CHECK(1), .DELAY_SLOT(1)) dut_a (
      .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .fwd_we_i(fwd_we_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .reg1_addr_o(a_r1a), .reg2_addr_o(a_r2a), .reg1_read_o(a_r1r), .reg2_read_o(a_r2r),
      .stallreq_o(a_stl), .branch_flag_o(a_bf), .branch_addr_o(a_ba), .squash_next_o(a_sq),
      .ex_aluop_o(a_ex_aluop), .ex_alusel_o(a_ex_alusel), .ex_reg1_o(a_ex_reg1),
      .ex_reg2_o(a_ex_reg2), .ex_wd_o(a_ex_wd), .ex_wreg_o(a_ex_wreg),
      .ex_in_delay_slot_o(a_ex_ids));

   id_fwd_stage #(.NUM_FWD(NF), .LOAD_USE_CHECK(0), .DELAY_SLOT(0)) dut_b (
      .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .fwd_we_i(fwd_we_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .reg1_addr_o(b_r1a), .reg2_addr_o(b_r2a), .reg1_read_o(b_r1r), .reg2_read_o(b_r2r),
      .stallreq_o(b_stl), .branch_flag_o(b_bf), .branch_addr_o(b_ba), .squash_next_o(b_sq),
      .ex_aluop_o(b_ex_aluop), .ex_alusel_o(b_ex_alusel), .ex_reg1_o(b_ex_reg1),
      .ex_reg2_o(b_ex_reg2), .ex_wd_o(b_ex_wd), .ex_wreg_o(b_ex_wreg),
      .ex_in_delay_slot_o(b_ex_ids));

   assign a_comb = {a_r1a, a_r2a, a_r1r, a_r2r, a_stl, a_bf, a_ba, a_sq};
   assign b_comb = {b_r1a, b_r2a, b_r1r, b_r2r, b_stl, b_bf, b_ba, b_sq};
   assign a_ex   = {a_ex_aluop, a_ex_alusel, a_ex_reg1, a_ex_reg2, a_ex_wd, a_ex_wreg, a_ex_ids};
   assign b_ex   = {b_ex_aluop, b_ex_alusel, b_ex_reg1, b_ex_reg2, b_ex_wd, b_ex_wreg, b_ex_ids};

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] im);
      return {op, rs, rt, im};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   // Register value as seen by the ID stage: r0, then nearest writer, then regfile.
   function automatic logic [31:0] src_val(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return 32'h0;
      for (int k = 0; k < NF; k++)
         if (fwd_we_i[k] && fwd_wd_i[5*k +: 5] == a) return fwd_wdata_i[32*k +: 32];
      return rf;
   endfunction

   function automatic void model(input bit luc, input bit dsl, input ex_t cur, input logic ds_cur,
                                 output logic [46:0] comb, output ex_t nxt, output logic ds_nxt);
      logic [5:0]  op;
      logic [4:0]  a1, a2, wd;
      logic        rd1, rd2, wreg, beq, bne, jmp, hz, tk;
      logic [7:0]  aluop;
      logic [2:0]  sel;
      logic [31:0] im, o1, o2, pc4, tgt, sx;
      op = inst_i[31:26];
      a1 = inst_i[25:21]; a2 = inst_i[20:16]; wd = inst_i[15:11];
      rd1 = 0; rd2 = 0; wreg = 0; beq = 0; bne = 0; jmp = 0;
      aluop = 8'h00; sel = 3'b000; im = 32'h0;
      sx = {{16{inst_i[15]}}, inst_i[15:0]};
      case (op)
         6'h0C, 6'h0D, 6'h0E: begin
            aluop = (op == 6'h0C) ? 8'h24 : (op == 6'h0D) ? 8'h25 : 8'h26;
            sel = 3'b001; rd1 = 1; wd = inst_i[20:16]; wreg = 1; im = {16'h0, inst_i[15:0]};
         end
         6'h0F: begin
            aluop = 8'h25; sel = 3'b001; rd1 = 1; a1 = 5'd0; im = {inst_i[15:0], 16'h0};
            wd = inst_i[20:16]; wreg = 1;
         end
         6'h00: if (inst_i[10:6] == 5'd0 && inst_i[5:0] >= 6'h24 && inst_i[5:0] <= 6'h27) begin
            aluop = {2'b00, inst_i[5:0]}; sel = 3'b001; rd1 = 1; rd2 = 1; wreg = 1;
         end
         6'h23: begin
            aluop = 8'hE3; sel = 3'b111; rd1 = 1; im = sx; wd = inst_i[20:16]; wreg = 1;
         end
         6'h04: begin rd1 = 1; rd2 = 1; beq = 1; end
         6'h05: begin rd1 = 1; rd2 = 1; bne = 1; end
         6'h02: jmp = 1;
         default: ;
      endcase
      o1  = rd1 ? src_val(a1, reg1_data_i) : im;
      o2  = rd2 ? src_val(a2, reg2_data_i) : im;
      pc4 = pc_i + 32'd4;
      tgt = jmp ? {pc4[31:28], inst_i[25:0], 2'b00} : pc4 + (sx << 2);
      hz  = luc && cur.aluop == 8'hE3 && cur.wreg && cur.wd != 5'd0 &&
            ((rd1 && a1 == cur.wd) || (rd2 && a2 == cur.wd));
      tk  = (jmp || (beq && o1 == o2) || (bne && o1 != o2)) && !hz;
      comb = {a1, a2, rd1, rd2, hz, tk, (tk ? tgt : 32'h0), (!dsl && tk)};
      nxt = cur;
      ds_nxt = ds_cur;
      if (rst || flush_i) begin
         nxt = '0;
         ds_nxt = 1'b0;
      end else if (!stall_i) begin
         if (hz) nxt = '0;
         else begin
            nxt = '{aluop: aluop, alusel: sel, reg1: o1, reg2: o2, wd: wd, wreg: wreg, ids: ds_cur};
            ds_nxt = dsl && tk;
         end
      end
   endfunction

   task automatic step(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                       input logic st, input logic fl);
      logic [46:0] c;
      ex_t         n;
      logic        d;
      @(posedge clk);
      #1;
      rst = r; inst_i = inst; pc_i = pc; stall_i = st; flush_i = fl;
      reg1_data_i = nx_r1; reg2_data_i = nx_r2;
      fwd_we_i = nx_we; fwd_wd_i = nx_wd; fwd_wdata_i = nx_wdata;
      model(1'b1, 1'b1, st_a, ds_a, c, n, d);
      comb_a_q.push_back(c); exp_a_q.push_back(n); st_a = n; ds_a = d;
      model(1'b0, 1'b0, st_b, ds_b, c, n, d);
      comb_b_q.push_back(c); exp_b_q.push_back(n); st_b = n; ds_b = d;
      #1;
   endtask

   task automatic no_fwd();
      nx_we = '0; nx_wd = '0; nx_wdata = '0;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [4:0] rs, rt, rd;
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 11))
         0:  return itype(6'h0D, rs, rt, 16'($urandom));
         1:  return itype(6'h0C, rs, rt, 16'($urandom));
         2:  return itype(6'h0E, rs, rt, 16'($urandom));
         3:  return itype(6'h0F, rs, rt, 16'($urandom));
         4:  return rtype(rs, rt, rd, 5'd0, 6'(6'h24 + $urandom_range(0, 3)));
         5:  return rtype(rs, rt, rd, 5'($urandom_range(1, 31)), 6'(6'h24 + $urandom_range(0, 3)));
         6, 7: return itype(6'h23, rs, rt, 16'($urandom));
         8:  return itype(6'h04, rs, rt, 16'($urandom));
         9:  return itype(6'h05, rs, rt, 16'($urandom));
         10: return {6'h02, 26'($urandom)};
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard monitor: combinational responses belong to this cycle's
   // stimulus, registered responses to the previous cycle's.
   always @(negedge clk) begin
      if (mon_en) begin
         if (comb_a_q.size() > 0) chk("comb_a", 128'(a_comb), 128'(comb_a_q.pop_front()));
         if (comb_b_q.size() > 0) chk("comb_b", 128'(b_comb), 128'(comb_b_q.pop_front()));
         if (exp_a_q.size() >= 2) chk("ex_a", 128'(a_ex), 128'(exp_a_q.pop_front()));
         if (exp_b_q.size() >= 2) chk("ex_b", 128'(b_ex), 128'(exp_b_q.pop_front()));
      end
   end

   initial begin
      rst = 1'b1; pc_i = '0; inst_i = '0; reg1_data_i = '0; reg2_data_i = '0;
      fwd_we_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; stall_i = 1'b0; flush_i = 1'b0;
      nx_r1 = '0; nx_r2 = '0; no_fwd();
      st_a = '0; st_b = '0; ds_a = 1'b0; ds_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_a_q.push_back('0);
      exp_b_q.push_back('0);
      mon_en = 1'b1;

      // ORI r1 = r0 | 0x1234
      step(0, itype(6'h0D, 5'd0, 5'd1, 16'h1234), 32'h0, 0, 0);
      step(0, 32'h0, 32'h4, 0, 0);
      chk("ori_aluop", 128'(a_ex_aluop), 128'h25);
      chk("ori_reg1", 128'(a_ex_reg1), 128'h0);
      chk("ori_reg2", 128'(a_ex_reg2), 128'h1234);
      chk("ori_wd", 128'({a_ex_wd, a_ex_wreg}), 128'({5'd1, 1'b1}));

      // OR r3 = r1 | r2, two writers of r1
      nx_r1 = 32'h5; nx_r2 = 32'h9; nx_we = 2'b11;
      nx_wd = {5'd1, 5'd1}; nx_wdata = {32'hB, 32'hA};
      step(0, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), 32'h8, 0, 0);
      nx_wd = {5'd0, 5'd0};
      step(0, rtype(5'd0, 5'd2, 5'd3, 5'd0, 6'h25), 32'hC, 0, 0);
      chk("fwd_prio", 128'(a_ex_reg1), 128'hA);
      no_fwd();
      step(0, 32'h0, 32'h10, 0, 0);
      chk("fwd_r0", 128'(a_ex_reg1), 128'h0);

      // LW r4 then dependent ORI r5 = r4 | 1
      step(0, itype(6'h23, 5'd2, 5'd4, 16'h0010), 32'h14, 0, 0);
      step(0, itype(6'h0D, 5'd4, 5'd5, 16'h0001), 32'h18, 0, 0);
      chk("lu_stall_a", 128'(a_stl), 128'h1);
      chk("lu_stall_b", 128'(b_stl), 128'h0);
      step(0, itype(6'h0D, 5'd4, 5'd5, 16'h0001), 32'h18, 0, 0);
      chk("lu_bubble", 128'(a_ex_aluop), 128'h0);
      chk("lu_nocheck", 128'(b_ex_aluop), 128'h25);
      step(0, 32'h0, 32'h1C, 0, 0);
      chk("lu_resume", 128'(a_ex_aluop), 128'h25);

      // BEQ r1, r2 taken at 0x100, offset 4
      nx_r1 = 32'h7; nx_r2 = 32'h7;
      step(0, itype(6'h04, 5'd1, 5'd2, 16'h0004), 32'h100, 0, 0);
      chk("beq_flag", 128'(a_bf), 128'h1);
      chk("beq_addr", 128'(a_ba), 128'h114);
      chk("beq_sq", 128'({a_sq, b_sq}), 128'b01);
      step(0, itype(6'h0D, 5'd0, 5'd1, 16'h0002), 32'h104, 0, 0);
      step(0, 32'h0, 32'h108, 0, 0);
      chk("delay_slot", 128'({a_ex_ids, b_ex_ids}), 128'b10);

      // Stall hold, then flush together with stall
      step(0, itype(6'h0D, 5'd0, 5'd6, 16'h0055), 32'h10C, 0, 0);
      repeat (3) step(0, itype(6'h0E, 5'd1, 5'd7, 16'h00AA), 32'h110, 1, 0);
      step(0, 32'h0, 32'h114, 1, 0);
      chk("stall_hold", 128'({a_ex_aluop, a_ex_reg2}), 128'({8'h25, 32'h55}));
      step(0, itype(6'h0E, 5'd1, 5'd7, 16'h00AA), 32'h118, 1, 1);
      step(0, 32'h0, 32'h11C, 0, 0);
      chk("flush", 128'({a_ex_aluop, a_ex_reg2, a_ex_wreg}), 128'h0);

      // Reset mid-stream, then SPECIAL with nonzero shamt
      step(0, itype(6'h0D, 5'd0, 5'd7, 16'h0077), 32'h120, 0, 0);
      step(1, itype(6'h0D, 5'd0, 5'd7, 16'h0099), 32'h124, 0, 0);
      step(0, rtype(5'd1, 5'd2, 5'd3, 5'd3, 6'h25), 32'h128, 0, 0);
      chk("rst_mid", 128'({a_ex_aluop, a_ex_reg2, a_ex_wreg}), 128'h0);
      step(0, 32'h0, 32'h12C, 0, 0);
      chk("shamt_nop", 128'({a_ex_aluop, a_ex_wreg}), 128'h0);

      for (int i = 0; i < 500; i++) begin
         nx_r1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         nx_r2 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         nx_we = NF'($urandom);
         for (int k = 0; k < NF; k++) begin
            nx_wd[5*k +: 5]     = 5'($urandom_range(0, 7));
            nx_wdata[32*k +: 32] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
         end
         step(($urandom_range(0, 99) == 0), rand_inst(), {$urandom, 2'b00} >> 2 << 2,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      end

      no_fwd();
      step(0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      #1;
      chk("drain", 128'(exp_a_q.size() + exp_b_q.size() + comb_a_q.size() + comb_b_q.size()), 128'd2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
